// File: rtl/inst_fetcher.sv
// Instruction fetch front end: issues one memory request at a time and buffers
// returned words with their PCs in a circular queue presented to the decoder.
module inst_fetcher #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rstn_in,
  input  logic        rdy_in,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_inst,
  input  logic        if_station_idle,
  output logic [31:0] inst_to_dec,
  output logic [31:0] pc_to_dec,
  output logic        if_ls,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in
);
  localparam int               PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
  localparam logic [6:0]       OP_LOAD  = 7'b0000011;
  localparam logic [6:0]       OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      pc_q   [QDEPTH];
  logic [31:0]      inst_q [QDEPTH];
  logic             not_empty, not_full, push, pop;
  logic [31:0]      head_inst;

  assign not_empty = (count_reg != '0);
  assign not_full  = (count_reg < FULL_CNT);
  // A flush cancels both the accept of a returning word and any pop.
  assign push = (state_reg == S_WAIT) && mem_valid && !flush_in;
  assign pop  = not_empty && if_station_idle && !flush_in;

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      state_reg <= S_IDLE;
    end else if (rdy_in) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (not_full && !flush_in) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid)     state_next = S_IDLE;
        else if (flush_in) state_next = S_DISCARD;
      end
      S_DISCARD: begin
        if (mem_valid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_req  = rstn_in && rdy_in && (state_reg == S_IDLE) && not_full && !flush_in;
    fetch_addr = fetch_req ? fetch_pc_reg : 32'h0;
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    if (flush_in) begin
      fetch_pc_next = flush_pc_in;
      head_next     = '0;
      tail_next     = '0;
      count_next    = '0;
    end else begin
      if (push) begin
        tail_next     = tail_reg + PTR_W'(1);
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (pop) head_next = head_reg + PTR_W'(1);
      if (push && !pop)      count_next = count_reg + CNT_W'(1);
      else if (pop && !push) count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      fetch_pc_reg <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else if (rdy_in) begin
      fetch_pc_reg <= fetch_pc_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rstn_in && rdy_in && push) begin
      pc_q[tail_reg]   <= fetch_pc_reg;
      inst_q[tail_reg] <= mem_inst;
    end
  end

  assign head_inst   = inst_q[head_reg];
  assign inst_to_dec = not_empty ? head_inst : 32'h0;
  assign pc_to_dec   = not_empty ? pc_q[head_reg] : 32'h0;
  assign if_ls       = not_empty && ((head_inst[6:0] == OP_LOAD) || (head_inst[6:0] == OP_STORE));
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: latency-3 memory model, scoreboard of queued words,
// a vector table of instruction words and hand-written flush/reset sequences.
module tb_inst_fetcher;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          NVEC     = 10;

  logic        clk = 1'b0;
  logic        rstn_in, rdy_in, mem_valid, if_station_idle, flush_in;
  logic [31:0] mem_inst, flush_pc_in;
  logic        fetch_req, if_ls;
  logic [31:0] fetch_addr, inst_to_dec, pc_to_dec;

  inst_fetcher #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_in(clk), .rstn_in(rstn_in), .rdy_in(rdy_in),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .mem_valid(mem_valid), .mem_inst(mem_inst),
    .if_station_idle(if_station_idle),
    .inst_to_dec(inst_to_dec), .pc_to_dec(pc_to_dec), .if_ls(if_ls),
    .flush_in(flush_in), .flush_pc_in(flush_pc_in)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic exp_ls; } vec_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic ls; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] exp_addr; int due; logic drop; logic abandoned; } pend_t;

  vec_t        vecs [NVEC];
  exp_t        sb [$];
  exp_t        seen [$];
  pend_t       pend [$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          mem_time = 0;
  int          mem_lat  = 3;
  int          n_req    = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_req_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr < 32'(NVEC * 4)) return vecs[int'(addr >> 2)].inst;
    return {addr[19:0], 12'h013};
  endfunction

  function automatic logic mem_ls(input logic [31:0] addr);
    if (addr < 32'(NVEC * 4)) return vecs[int'(addr >> 2)].exp_ls;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive memory, check outputs against the model, advance the model.
  task automatic cycle();
    logic  deliver;
    logic  busy;
    logic  exp_req;
    pend_t p;
    deliver   = 1'b0;
    mem_valid = 1'b0;
    mem_inst  = 32'hDEAD_BEEF;
    if (rdy_in && pend.size() > 0 && pend[0].due == mem_time) begin
      p         = pend.pop_front();
      deliver   = 1'b1;
      mem_valid = 1'b1;
      mem_inst  = mem_word(p.addr);
    end
    #1;
    busy = deliver && !p.abandoned;
    foreach (pend[k]) if (!pend[k].abandoned) busy = 1'b1;
    exp_req = rstn_in && rdy_in && !flush_in && (sb.size() < QDEPTH) && !busy;
    chk("fetch_req", 32'(fetch_req), 32'(exp_req));
    if (exp_req && fetch_req) begin
      chk("fetch_addr", fetch_addr, exp_pc);
      $display("req  addr=%h t=%0t", fetch_addr, $time);
      n_req++;
      last_req_addr = fetch_addr;
      pend.push_back('{addr: fetch_addr, exp_addr: exp_pc, due: mem_time + mem_lat,
                       drop: 1'b0, abandoned: 1'b0});
    end
    if (sb.size() > 0) begin
      chk("inst_to_dec", inst_to_dec, sb[0].inst);
      chk("pc_to_dec", pc_to_dec, sb[0].pc);
      chk("if_ls", 32'(if_ls), 32'(sb[0].ls));
    end else begin
      chk("empty_inst", inst_to_dec, 32'h0);
      chk("empty_pc", pc_to_dec, 32'h0);
      chk("empty_ls", 32'(if_ls), 32'h0);
    end
    if (rstn_in && rdy_in && !flush_in && if_station_idle && sb.size() > 0) begin
      $display("pop  pc=%h inst=%h ls=%0d", pc_to_dec, inst_to_dec, if_ls);
      seen.push_back('{pc: pc_to_dec, inst: inst_to_dec, ls: if_ls});
      void'(sb.pop_front());
    end
    if (deliver && rstn_in && !flush_in && !p.drop) begin
      sb.push_back('{pc: p.exp_addr, inst: mem_word(p.exp_addr), ls: mem_ls(p.exp_addr)});
      exp_pc = p.exp_addr + 32'd4;
    end
    if (!rstn_in) begin
      sb.delete();
      exp_pc = RESET_PC;
      foreach (pend[k]) begin
        pend[k].drop      = 1'b1;
        pend[k].abandoned = 1'b1;
      end
    end else if (rdy_in && flush_in) begin
      sb.delete();
      exp_pc = flush_pc_in;
      foreach (pend[k]) pend[k].drop = 1'b1;
    end
    if (rdy_in) mem_time++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic flush_to(input logic [31:0] pc);
    flush_in    = 1'b1;
    flush_pc_in = pc;
    cycle();
    flush_in    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int base;
    vecs[0] = '{inst: 32'h00000013, exp_ls: 1'b0};
    vecs[1] = '{inst: 32'h00a00093, exp_ls: 1'b0};
    vecs[2] = '{inst: 32'h00012083, exp_ls: 1'b1};
    vecs[3] = '{inst: 32'h00112023, exp_ls: 1'b1};
    vecs[4] = '{inst: 32'h00208033, exp_ls: 1'b0};
    vecs[5] = '{inst: 32'h00000000, exp_ls: 1'b0};
    vecs[6] = '{inst: 32'h00000003, exp_ls: 1'b1};
    vecs[7] = '{inst: 32'h00000023, exp_ls: 1'b1};
    vecs[8] = '{inst: 32'h00000063, exp_ls: 1'b0};
    vecs[9] = '{inst: 32'h0000007f, exp_ls: 1'b0};

    rstn_in = 1'b0; rdy_in = 1'b1; mem_valid = 1'b0; mem_inst = 32'h0;
    if_station_idle = 1'b0; flush_in = 1'b0; flush_pc_in = 32'h0;
    exp_pc = RESET_PC;
    @(negedge clk);
    #1;
    chk("reset_fetch_req", 32'(fetch_req), 32'h0);
    chk("reset_fetch_addr", fetch_addr, 32'h0);
    chk("reset_inst", inst_to_dec, 32'h0);
    chk("reset_pc", pc_to_dec, 32'h0);
    chk("reset_ls", 32'(if_ls), 32'h0);
    run(2);
    rstn_in = 1'b1;

    // Vector table: straight-line fetch from RESET_PC with the decoder always idle.
    if_station_idle = 1'b1;
    budget = 0;
    while (seen.size() < NVEC && budget < 200) begin cycle(); budget++; end
    chk("table_timeout", 32'(seen.size() >= NVEC), 32'h1);
    for (int i = 0; i < NVEC; i++) begin
      if (i < seen.size()) begin
        chk("table_inst", seen[i].inst, vecs[i].inst);
        chk("table_pc", seen[i].pc, 32'(i * 4));
        chk("table_ls", 32'(seen[i].ls), 32'(vecs[i].exp_ls));
      end
    end

    // Backpressure: exactly QDEPTH requests, then one pop allows one refill.
    if_station_idle = 1'b0;
    flush_to(32'h1000);
    base = n_req;
    run(40);
    chk("bp_requests", 32'(n_req - base), 32'(QDEPTH));
    chk("bp_count", 32'(sb.size()), 32'(QDEPTH));
    base = seen.size();
    if_station_idle = 1'b1;
    cycle();
    if_station_idle = 1'b0;
    chk("bp_one_pop", 32'(seen.size() - base), 32'h1);
    base = n_req;
    run(20);
    chk("bp_refill", 32'(n_req - base), 32'h1);
    chk("bp_refill_addr", last_req_addr, 32'h1010);

    // Flush while the request to 0x8 is outstanding.
    flush_to(32'h0);
    budget = 0;
    while (!(last_req_addr == 32'h8 && pend.size() > 0) && budget < 60) begin cycle(); budget++; end
    chk("wait8_timeout", 32'(budget < 60), 32'h1);
    flush_to(32'h100);
    #1;
    chk("flush_wait_inst", inst_to_dec, 32'h0);
    chk("flush_wait_pc", pc_to_dec, 32'h0);
    base = n_req;
    budget = 0;
    while (n_req == base && budget < 30) begin cycle(); budget++; end
    chk("flush_wait_addr", last_req_addr, 32'h100);

    // Flush in the same cycle as the memory return.
    if_station_idle = 1'b1;
    budget = 0;
    while (!(pend.size() > 0 && pend[0].due == mem_time) && budget < 30) begin cycle(); budget++; end
    flush_to(32'h180);
    base = n_req;
    budget = 0;
    while (n_req == base && budget < 30) begin cycle(); budget++; end
    chk("flush_coinc_addr", last_req_addr, 32'h180);

    // Two flushes while discarding: the later PC wins.
    budget = 0;
    while (!(pend.size() > 0 && pend[0].due == mem_time + mem_lat - 1) && budget < 30) begin cycle(); budget++; end
    flush_to(32'h200);
    flush_to(32'h300);
    base = n_req;
    budget = 0;
    while (n_req == base && budget < 30) begin cycle(); budget++; end
    chk("discard_addr", last_req_addr, 32'h300);

    // rdy_in low with a queued head and a request in flight.
    if_station_idle = 1'b0;
    flush_to(32'h400);
    budget = 0;
    while (!(sb.size() == 1 && pend.size() > 0) && budget < 40) begin cycle(); budget++; end
    chk("rdy_setup_timeout", 32'(budget < 40), 32'h1);
    rdy_in = 1'b0;
    if_station_idle = 1'b1;
    run(5);
    #1;
    chk("rdy_head_pc", pc_to_dec, 32'h400);
    chk("rdy_head_inst", inst_to_dec, mem_word(32'h400));
    rdy_in = 1'b1;
    if_station_idle = 1'b0;
    run(6);

    // Reset in the middle of a request; the late return must be ignored.
    budget = 0;
    while (!(pend.size() > 0 && !pend[0].abandoned && pend[0].due == mem_time + 1) && budget < 40) begin
      cycle(); budget++;
    end
    chk("rst_setup_timeout", 32'(budget < 40), 32'h1);
    rstn_in = 1'b0;
    cycle();
    rstn_in = 1'b1;
    #1;
    chk("rst_mid_inst", inst_to_dec, 32'h0);
    chk("rst_mid_pc", pc_to_dec, 32'h0);
    chk("rst_mid_ls", 32'(if_ls), 32'h0);
    chk("rst_mid_req_addr", fetch_addr, RESET_PC);
    if_station_idle = 1'b1;
    base = seen.size();
    budget = 0;
    while (seen.size() < base + 3 && budget < 60) begin cycle(); budget++; end
    for (int k = 0; k < 3; k++) begin
      if (base + k < seen.size()) begin
        chk("rst_restart_pc", seen[base + k].pc, RESET_PC + 32'(k * 4));
        chk("rst_restart_inst", seen[base + k].inst, vecs[k].inst);
      end else begin
        chk("rst_restart_count", 32'(seen.size() - base), 32'h3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
